mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mult_div_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the multicycle control unit and the
// sequential multiply/divide unit.
interface mult_div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_mult;
  logic                  start_div;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] hi_out;
  logic [DATA_WIDTH-1:0] lo_out;
  logic                  busy;
  logic                  done;
  logic                  div_zero;

  // Control unit side: issues requests, reads HI/LO and status.
  modport master (
    output start_mult, start_div, op_a, op_b,
    input  hi_out, lo_out, busy, done, div_zero
  );

  // Arithmetic unit side.
  modport slave (
    input  start_mult, start_div, op_a, op_b,
    output hi_out, lo_out, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit.
// Multiply: radix-2 Booth, one iteration per clock, DATA_WIDTH iterations.
// Divide: restoring division on operand magnitudes, one quotient bit per
// clock, with sign fix-up on the way out (truncation toward zero).
// HI/LO only change in the FINISH cycle, so MFHI/MFLO see old results
// while an operation is in flight.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic            clock,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULT   = 2'd1,
    ST_DIV    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic            is_mult_r;
  logic            dz_r;

  // Booth accumulator layout: {A[W-1:0], Q[W-1:0], q_minus1}.
  logic [2*W:0]    acc_r;
  logic [W-1:0]    mcand_r;

  // Divider state: remainder, dividend/quotient shift register, divisor.
  logic [W-1:0]    rem_r;
  logic [W-1:0]    quo_r;
  logic [W-1:0]    dvs_r;
  logic            neg_q_r;
  logic            neg_r_r;

  logic [W-1:0]    hi_r;
  logic [W-1:0]    lo_r;
  logic            busy_r;
  logic            done_r;
  logic            div_zero_r;

  logic [W:0]      booth_sum_s;
  logic [2*W:0]    booth_next_s;
  logic [W:0]      part_rem_s;
  logic [W-1:0]    rem_next_s;
  logic [W-1:0]    quo_next_s;
  logic [W-1:0]    q_fin_s;
  logic [W-1:0]    r_fin_s;
  logic [W-1:0]    mag_a_s;
  logic [W-1:0]    mag_b_s;

  // One Booth step: add/subtract on a sign-extended A so the most negative
  // multiplicand cannot overflow, then arithmetic shift right by one.
  always_comb begin
    booth_sum_s = {acc_r[2*W], acc_r[2*W:W+1]};
    case (acc_r[1:0])
      2'b01:   booth_sum_s = {acc_r[2*W], acc_r[2*W:W+1]} + {mcand_r[W-1], mcand_r};
      2'b10:   booth_sum_s = {acc_r[2*W], acc_r[2*W:W+1]} - {mcand_r[W-1], mcand_r};
      default: booth_sum_s = {acc_r[2*W], acc_r[2*W:W+1]};
    endcase
    booth_next_s = {booth_sum_s, acc_r[W:1]};
  end

  // One restoring-division step on magnitudes: shift in the next dividend
  // bit and subtract the divisor when it fits.
  always_comb begin
    part_rem_s = {rem_r, quo_r[W-1]};
    if (part_rem_s >= {1'b0, dvs_r}) begin
      rem_next_s = W'(part_rem_s - {1'b0, dvs_r});
      quo_next_s = {quo_r[W-2:0], 1'b1};
    end else begin
      rem_next_s = part_rem_s[W-1:0];
      quo_next_s = {quo_r[W-2:0], 1'b0};
    end
  end

  // Sign fix-up of the divide result and operand magnitudes for a new divide.
  always_comb begin
    if (neg_q_r) begin
      q_fin_s = {W{1'b0}} - quo_r;
    end else begin
      q_fin_s = quo_r;
    end
    if (neg_r_r) begin
      r_fin_s = {W{1'b0}} - rem_r;
    end else begin
      r_fin_s = rem_r;
    end
    if (bus.op_a[W-1]) begin
      mag_a_s = {W{1'b0}} - bus.op_a;
    end else begin
      mag_a_s = bus.op_a;
    end
    if (bus.op_b[W-1]) begin
      mag_b_s = {W{1'b0}} - bus.op_b;
    end else begin
      mag_b_s = bus.op_b;
    end
  end

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      is_mult_r  <= 1'b0;
      dz_r       <= 1'b0;
      acc_r      <= {(2*W+1){1'b0}};
      mcand_r    <= {W{1'b0}};
      rem_r      <= {W{1'b0}};
      quo_r      <= {W{1'b0}};
      dvs_r      <= {W{1'b0}};
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      hi_r       <= {W{1'b0}};
      lo_r       <= {W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (bus.start_mult) begin
            // Multiply has priority over a simultaneous divide request.
            is_mult_r <= 1'b1;
            dz_r      <= 1'b0;
            mcand_r   <= bus.op_a;
            acc_r     <= {{W{1'b0}}, bus.op_b, 1'b0};
            busy_r    <= 1'b1;
            state_r   <= ST_MULT;
          end else if (bus.start_div) begin
            is_mult_r <= 1'b0;
            busy_r    <= 1'b1;
            if (bus.op_b == {W{1'b0}}) begin
              dz_r    <= 1'b1;
              state_r <= ST_FINISH;
            end else begin
              dz_r    <= 1'b0;
              rem_r   <= {W{1'b0}};
              quo_r   <= mag_a_s;
              dvs_r   <= mag_b_s;
              neg_q_r <= bus.op_a[W-1] ^ bus.op_b[W-1];
              neg_r_r <= bus.op_a[W-1];
              state_r <= ST_DIV;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MULT: begin
          acc_r <= booth_next_s;
          if (cnt_r == CW'(W - 1)) begin
            state_r <= ST_FINISH;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_DIV: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          if (cnt_r == CW'(W - 1)) begin
            state_r <= ST_FINISH;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_FINISH: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
          if (dz_r) begin
            // HI/LO keep their previous contents on divide-by-zero.
            div_zero_r <= 1'b1;
          end else if (is_mult_r) begin
            hi_r <= acc_r[2*W:W+1];
            lo_r <= acc_r[W:1];
          end else begin
            hi_r <= r_fin_s;
            lo_r <= q_fin_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi_out   = hi_r;
  assign bus.lo_out   = lo_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus
// randomized multiply/divide traffic against a plain-arithmetic model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clock = ~clock;

  mult_div_unit_if #(.DATA_WIDTH(W)) bus ();

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: signed 64-bit product, or truncating signed division.
  task automatic model_op(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b,
                          output bit dz);
    longint pa, pb, p, q, r;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    dz = 1'b0;
    if (is_mult) begin
      p = pa * pb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
    end else begin
      q = pa / pb;
      r = pa % pb;
      exp_hi = r[31:0];
      exp_lo = q[31:0];
    end
  endtask

  // Issue one request at the current negedge and follow it to done.
  // inject > 0 pulses both start lines in that busy cycle.
  task automatic run_op(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject);
    bit dz;
    bit seen;
    bit bad;
    int n;
    logic [W-1:0] old_hi, old_lo;
    old_hi = exp_hi;
    old_lo = exp_lo;
    model_op(is_mult, a, b, dz);
    bus.start_mult = is_mult;
    bus.start_div  = !is_mult;
    bus.op_a = a;
    bus.op_b = b;
    @(posedge clock);
    @(negedge clock);
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    n = 0;
    seen = 1'b0;
    bad = 1'b0;
    while (!seen && n < 40) begin
      if (!dz && (bus.busy !== 1'b1 || bus.hi_out !== old_hi || bus.lo_out !== old_lo))
        bad = 1'b1;
      @(posedge clock);
      n++;
      @(negedge clock);
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
      end else if (n == inject) begin
        bus.start_mult = 1'b1;
        bus.start_div  = 1'b1;
      end
    end
    check_val("busy_hold", {63'd0, bad}, 64'd0);
    check_val("latency", n, dz ? 64'd1 : 64'd33);
    check_val("hi", bus.hi_out, exp_hi);
    check_val("lo", bus.lo_out, exp_lo);
    check_val("div_zero", bus.div_zero, dz);
    check_val("busy_at_done", bus.busy, 64'd0);
  endtask

  // One cycle after done: pulse over, unit idle.
  task automatic check_idle();
    @(negedge clock);
    check_val("done_pulse", bus.done, 64'd0);
    check_val("dz_pulse", bus.div_zero, 64'd0);
    check_val("idle_busy", bus.busy, 64'd0);
  endtask

  // No done may appear for the given number of cycles.
  task automatic watch_quiet(input int cycles);
    bit any;
    any = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) any = 1'b1;
    end
    check_val("quiet", {63'd0, any}, 64'd0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h8000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h7FFF_FFFF;
      3:       v = W'($signed($urandom_range(0, 40)) - 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [W-1:0] a, b;
    bit           m;
    int           inj;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (3) @(negedge clock);
    check_val("rst_hi", bus.hi_out, 64'd0);
    check_val("rst_lo", bus.lo_out, 64'd0);
    check_val("rst_busy", bus.busy, 64'd0);
    check_val("rst_done", bus.done, 64'd0);
    check_val("rst_dz", bus.div_zero, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // 7 * -3
    run_op(1'b1, 32'd7, 32'hFFFF_FFFD, 0);
    check_val("t1_hi", bus.hi_out, 64'hFFFF_FFFF);
    check_val("t1_lo", bus.lo_out, 64'hFFFF_FFEB);
    check_idle();

    // Back-to-back multiplies at the extremes.
    run_op(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    check_val("t2a_hi", bus.hi_out, 64'h3FFF_FFFF);
    check_val("t2a_lo", bus.lo_out, 64'h0000_0001);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
    check_val("t2b_hi", bus.hi_out, 64'h4000_0000);
    check_val("t2b_lo", bus.lo_out, 64'h0);
    check_idle();

    // Signed divides.
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    check_val("t3a_lo", bus.lo_out, 64'hFFFF_FFFD);
    check_val("t3a_hi", bus.hi_out, 64'hFFFF_FFFF);
    check_idle();
    run_op(1'b0, 32'd100, 32'd7, 0);
    check_val("t3b_lo", bus.lo_out, 64'd14);
    check_val("t3b_hi", bus.hi_out, 64'd2);
    check_idle();

    // Preload hi=0x11 lo=0x22, then divide by zero.
    run_op(1'b0, 32'h451, 32'h20, 0);
    check_idle();
    run_op(1'b0, 32'd5, 32'd0, 0);
    check_val("t4_hi", bus.hi_out, 64'h11);
    check_val("t4_lo", bus.lo_out, 64'h22);
    check_idle();

    // Overflowing divide with a start pulse injected while busy.
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check_val("t5_lo", bus.lo_out, 64'h8000_0000);
    check_val("t5_hi", bus.hi_out, 64'h0);
    check_idle();
    watch_quiet(40);

    // Asynchronous reset in the middle of a multiply.
    bus.start_mult = 1'b1;
    bus.op_a = 32'd123456;
    bus.op_b = 32'd789;
    @(posedge clock);
    @(negedge clock);
    bus.start_mult = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_val("t6_hi", bus.hi_out, 64'd0);
    check_val("t6_lo", bus.lo_out, 64'd0);
    check_val("t6_busy", bus.busy, 64'd0);
    check_val("t6_done", bus.done, 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clock);
    reset = 1'b1;
    watch_quiet(45);
    check_val("t6_hi_after", bus.hi_out, 64'd0);

    // Randomized traffic, alternating back-to-back and spaced requests.
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      a = pick_operand();
      b = ($urandom_range(0, 7) == 0) ? '0 : pick_operand();
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 30)) : 0;
      run_op(m, a, b, inj);
      if (i % 2 == 1) check_idle();
    end
    check_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
